// File: rtl/mining_pkg.sv
// Shared types and widths for the mining datapath: scheduler FSM states,
// result status codes and bus widths used by the scheduler and the SPI FSM.
package mining_pkg;

  localparam int unsigned MIDSTATE_W = 256;
  localparam int unsigned BLOCK_W    = 512;
  localparam int unsigned HASH_W     = 256;
  localparam int unsigned NONCE_W    = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    REPORT
  } sched_state_t;

  typedef enum logic [1:0] {
    FOUND     = 2'd0,
    EXHAUSTED = 2'd1,
    TIMEOUT   = 2'd2,
    ABORTED   = 2'd3
  } result_status_t;

endpackage

// File: rtl/hash_target_compare.sv
// Combinational unsigned hash < target test (bit 0 of the big-endian numbering
// is the vector MSB, so a plain unsigned compare of the packed vectors applies).
//   hash             : candidate hash
//   target           : difficulty target
//   hash_lt_target_c : 1 when hash is strictly below target
module hash_target_compare
  import mining_pkg::*;
#(
  parameter int unsigned W = HASH_W
) (
  input  logic [W-1:0] hash,
  input  logic [W-1:0] target,
  output logic         hash_lt_target_c
);

  assign hash_lt_target_c = (hash < target);

endmodule

// File: rtl/nonce_sweep_scheduler.sv
// Sweeps a nonce range through the double-SHA-256 core for one job and reports
// the first winning nonce, exhaustion, core timeout or abort.
//   job_*      : job handshake and payload from the SPI FSM
//   abort      : cancel the running job (ignored in IDLE/REPORT)
//   core_*     : start pulse, midstate and nonce-patched block2 to the core;
//                core_done/core_hash back from it
//   result_*   : result payload held with result_valid until result_ack
//   busy       : scheduler not idle
module nonce_sweep_scheduler
  import mining_pkg::*;
#(
  parameter int unsigned NONCE_LSB      = 127,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [MIDSTATE_W-1:0] job_midstate,
  input  logic [BLOCK_W-1:0]    job_block2,
  input  logic [HASH_W-1:0]     job_target,
  input  logic [NONCE_W-1:0]    nonce_start,
  input  logic [NONCE_W-1:0]    nonce_end,
  input  logic                  abort,
  output logic                  core_start,
  output logic [MIDSTATE_W-1:0] core_midstate,
  output logic [BLOCK_W-1:0]    core_block2,
  input  logic                  core_done,
  input  logic [HASH_W-1:0]     core_hash,
  output logic                  result_valid,
  input  logic                  result_ack,
  output logic [1:0]            result_status,
  output logic [NONCE_W-1:0]    result_nonce,
  output logic [HASH_W-1:0]     result_hash,
  output logic                  busy
);

  // Big-endian bit NONCE_LSB maps to packed index BLOCK_W-1-NONCE_LSB.
  localparam int unsigned NONCE_POS = BLOCK_W - 1 - NONCE_LSB;
  localparam int unsigned CNT_W     = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t          state_q, state_d;
  logic                  job_ready_q, job_ready_d;
  logic                  busy_q, busy_d;
  logic                  core_start_q, core_start_d;
  logic [MIDSTATE_W-1:0] core_midstate_q, core_midstate_d;
  logic [BLOCK_W-1:0]    core_block2_q, core_block2_d;
  logic                  result_valid_q, result_valid_d;
  result_status_t        result_status_q, result_status_d;
  logic [NONCE_W-1:0]    result_nonce_q, result_nonce_d;
  logic [HASH_W-1:0]     result_hash_q, result_hash_d;
  logic [HASH_W-1:0]     target_q, target_d;
  logic [HASH_W-1:0]     hash_q, hash_d;
  logic [NONCE_W-1:0]    nonce_end_q, nonce_end_d;
  logic [NONCE_W-1:0]    cur_nonce_q, cur_nonce_d;
  logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]      tmo_inc;
  logic                  hash_lt_c;

  hash_target_compare #(.W(HASH_W)) u_cmp (
    .hash             (hash_q),
    .target           (target_q),
    .hash_lt_target_c (hash_lt_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state_q;
    core_start_d    = 1'b0;
    core_midstate_d = core_midstate_q;
    core_block2_d   = core_block2_q;
    result_valid_d  = result_valid_q;
    result_status_d = result_status_q;
    result_nonce_d  = result_nonce_q;
    result_hash_d   = result_hash_q;
    target_d        = target_q;
    hash_d          = hash_q;
    nonce_end_d     = nonce_end_q;
    cur_nonce_d     = cur_nonce_q;
    tmo_cnt_d       = tmo_cnt_q;
    tmo_inc         = tmo_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (job_valid && job_ready_q) begin
          target_d    = job_target;
          nonce_end_d = nonce_end;
          cur_nonce_d = nonce_start;
          if (nonce_end < nonce_start) begin
            state_d         = REPORT;
            result_valid_d  = 1'b1;
            result_status_d = EXHAUSTED;
            result_nonce_d  = nonce_start;
            result_hash_d   = '0;
          end else begin
            state_d         = ISSUE;
            core_start_d    = 1'b1;
            core_midstate_d = job_midstate;
            core_block2_d   = job_block2;
            core_block2_d[NONCE_POS +: NONCE_W] = nonce_start;
          end
        end
      end
      ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        tmo_cnt_d = tmo_inc;
        if (core_done) begin
          hash_d  = core_hash;
          state_d = CHECK;
        end else if (tmo_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d         = REPORT;
          result_valid_d  = 1'b1;
          result_status_d = TIMEOUT;
          result_nonce_d  = cur_nonce_q;
          result_hash_d   = '0;
        end
      end
      CHECK: begin
        if (hash_lt_c) begin
          state_d         = REPORT;
          result_valid_d  = 1'b1;
          result_status_d = FOUND;
          result_nonce_d  = cur_nonce_q;
          result_hash_d   = hash_q;
        end else if (cur_nonce_q == nonce_end_q) begin
          // Equality terminates, so an end of all-ones never wraps to 0.
          state_d         = REPORT;
          result_valid_d  = 1'b1;
          result_status_d = EXHAUSTED;
          result_nonce_d  = cur_nonce_q;
          result_hash_d   = hash_q;
        end else begin
          state_d      = ISSUE;
          core_start_d = 1'b1;
          cur_nonce_d  = cur_nonce_q + NONCE_W'(1);
          core_block2_d[NONCE_POS +: NONCE_W] = cur_nonce_q + NONCE_W'(1);
        end
      end
      REPORT: begin
        if (result_ack) begin
          result_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything in the active states, including core_done.
    if (abort && (state_q inside {ISSUE, WAIT, CHECK})) begin
      state_d         = REPORT;
      core_start_d    = 1'b0;
      core_block2_d   = core_block2_q;
      cur_nonce_d     = cur_nonce_q;
      result_valid_d  = 1'b1;
      result_status_d = ABORTED;
      result_nonce_d  = cur_nonce_q;
      result_hash_d   = '0;
    end

    job_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      job_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      core_start_q    <= 1'b0;
      core_midstate_q <= '0;
      core_block2_q   <= '0;
      result_valid_q  <= 1'b0;
      result_status_q <= FOUND;
      result_nonce_q  <= '0;
      result_hash_q   <= '0;
      target_q        <= '0;
      hash_q          <= '0;
      nonce_end_q     <= '0;
      cur_nonce_q     <= '0;
      tmo_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      job_ready_q     <= job_ready_d;
      busy_q          <= busy_d;
      core_start_q    <= core_start_d;
      core_midstate_q <= core_midstate_d;
      core_block2_q   <= core_block2_d;
      result_valid_q  <= result_valid_d;
      result_status_q <= result_status_d;
      result_nonce_q  <= result_nonce_d;
      result_hash_q   <= result_hash_d;
      target_q        <= target_d;
      hash_q          <= hash_d;
      nonce_end_q     <= nonce_end_d;
      cur_nonce_q     <= cur_nonce_d;
      tmo_cnt_q       <= tmo_cnt_d;
    end
  end

  assign job_ready     = job_ready_q;
  assign busy          = busy_q;
  assign core_start    = core_start_q;
  assign core_midstate = core_midstate_q;
  assign core_block2   = core_block2_q;
  assign result_valid  = result_valid_q;
  assign result_status = result_status_q;
  assign result_nonce  = result_nonce_q;
  assign result_hash   = result_hash_q;

endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// Scoreboard bench for nonce_sweep_scheduler: a behavioural job model predicts
// the nonce sequence sent to the core and the final result; a core model
// answers core_start, and a result monitor checks and acknowledges results.
module tb_nonce_sweep_scheduler;
  import mining_pkg::*;

  localparam int unsigned TB_NONCE_LSB = 127;
  localparam int unsigned TB_TIMEOUT   = 255;
  localparam int MODE_NORMAL  = 0;
  localparam int MODE_NODONE  = 1;
  localparam int MODE_ABORT   = 2;

  typedef struct {
    logic [1:0]   status;
    logic [31:0]  nonce;
    logic [255:0] hash;
    bit           chk_hash;
    bit           chk_timing;
    int           ack_delay;
  } exp_res_t;

  typedef struct {
    logic [255:0] mid;
    logic [511:0] blk;
    logic [31:0]  nonce;
  } exp_iss_t;

  logic         clk, rst;
  logic         job_valid, job_ready, abort, core_start, core_done;
  logic [255:0] job_midstate, job_target, core_midstate, core_hash, result_hash;
  logic [511:0] job_block2, core_block2;
  logic [31:0]  nonce_start, nonce_end, result_nonce;
  logic         result_valid, result_ack, busy;
  logic [1:0]   result_status;

  exp_res_t rq[$];
  exp_iss_t iq[$];
  int errors, checks, cyc, last_start_cyc, results_seen;
  int core_mode, core_lat, stray_req;
  bit abort_arm;

  nonce_sweep_scheduler #(.NONCE_LSB(TB_NONCE_LSB), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_midstate(job_midstate), .job_block2(job_block2), .job_target(job_target),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .abort(abort),
    .core_start(core_start), .core_midstate(core_midstate), .core_block2(core_block2),
    .core_done(core_done), .core_hash(core_hash), .result_valid(result_valid),
    .result_ack(result_ack), .result_status(result_status), .result_nonce(result_nonce),
    .result_hash(result_hash), .busy(busy)
  );

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;
  initial begin
    cyc = 0;
    forever begin @(posedge clk); cyc++; end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Nonce placement in big-endian [0:511] numbering: bit (NONCE_LSB-31+i) carries nonce bit 31-i.
  function automatic logic [511:0] with_nonce(input logic [511:0] blk, input logic [31:0] n);
    logic [511:0] b;
    b = blk;
    for (int i = 0; i < 32; i++) b[511 - (TB_NONCE_LSB - 31 + i)] = n[31 - i];
    return b;
  endfunction

  function automatic logic [31:0] get_nonce(input logic [511:0] blk);
    logic [31:0] n;
    for (int i = 0; i < 32; i++) n[31 - i] = blk[511 - (TB_NONCE_LSB - 31 + i)];
    return n;
  endfunction

  // Stand-in for double SHA-256: any deterministic function of midstate and nonce.
  function automatic logic [255:0] model_hash(input logic [255:0] mid, input logic [31:0] n);
    logic [31:0] m;
    m = n * 32'h9E3779B9;
    return {mid[255:224] ^ m, mid[223:32] ^ {6{m ^ 32'h5A5A0F0F}}, n};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_job_ready"}, 256'(job_ready), 256'(1));
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_result_valid"}, 256'(result_valid), 256'(0));
    check({tag, "_core_start"}, 256'(core_start), 256'(0));
  endtask

  task automatic recover();
    rst = 1'b1; tick(1); rst = 1'b0;
    rq.delete(); iq.delete();
  endtask

  // Predicts the job outcome, queues expectations, drives the job and waits for its result.
  task automatic run_job(input logic [255:0] mid, input logic [511:0] blk, input logic [255:0] tgt,
                         input logic [31:0] s, input logic [31:0] e, input int mode,
                         input int lat, input int ack_delay);
    exp_res_t r;
    exp_iss_t is;
    logic [255:0] h;
    int goal, k;
    r = '{status: 2'(EXHAUSTED), nonce: s, hash: '0, chk_hash: 1'b1, chk_timing: 1'b0,
          ack_delay: ack_delay};
    if (e < s) begin
      r.status = 2'(EXHAUSTED);
    end else if (mode != MODE_NORMAL) begin
      is = '{mid: mid, blk: with_nonce(blk, s), nonce: s};
      iq.push_back(is);
      if (mode == MODE_NODONE) begin
        r.status = 2'(TIMEOUT); r.chk_hash = 1'b0; r.chk_timing = 1'b1;
      end else begin
        r.status = 2'(ABORTED);
      end
    end else begin
      for (longint unsigned n = 64'(s); n <= 64'(e); n++) begin
        is = '{mid: mid, blk: with_nonce(blk, 32'(n)), nonce: 32'(n)};
        iq.push_back(is);
        h = model_hash(mid, 32'(n));
        r.nonce = 32'(n); r.hash = h;
        if (h < tgt) begin r.status = 2'(FOUND); break; end
        r.status = 2'(EXHAUSTED);
      end
    end
    rq.push_back(r);
    core_mode = mode; core_lat = lat; abort_arm = (mode == MODE_ABORT);
    goal = results_seen + 1;
    k = 0;
    while (!job_ready && k < 2000) begin tick(1); k++; end
    job_midstate = mid; job_block2 = blk; job_target = tgt; nonce_start = s; nonce_end = e;
    job_valid = 1'b1; tick(1); job_valid = 1'b0;
    k = 0;
    while (results_seen < goal && k < 5000) begin tick(1); k++; end
    if (results_seen < goal) begin
      check("job_complete_bound", 256'(results_seen), 256'(goal));
      recover();
    end
    abort_arm = 1'b0; core_mode = MODE_NORMAL;
  endtask

  // Hash-core model: checks each issued nonce and answers after core_lat cycles.
  initial begin
    int cnt, served;
    logic [255:0] mid;
    logic [31:0] n;
    exp_iss_t is;
    cnt = 0; served = 0; core_done = 1'b0; core_hash = '0; abort = 1'b0;
    forever begin
      @(posedge clk); #1;
      core_done = 1'b0; abort = 1'b0;
      if (core_start) begin
        last_start_cyc = cyc;
        mid = core_midstate; n = get_nonce(core_block2);
        if (iq.size() == 0) begin
          check("unexpected_core_start", 256'(1), 256'(0));
        end else begin
          is = iq.pop_front();
          check("core_nonce", 256'(n), 256'(is.nonce));
          check("core_midstate", core_midstate, is.mid);
          check("core_block2_lo", 256'(core_block2[255:0]), is.blk[255:0]);
          check("core_block2_hi", 256'(core_block2[511:256]), is.blk[511:256]);
        end
        cnt = (core_mode == MODE_NODONE) ? 0 : core_lat;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_done = 1'b1;
          core_hash = model_hash(mid, n);
          if (abort_arm) abort = 1'b1;
        end
      end
      if (stray_req != served) begin
        served = stray_req;
        core_done = 1'b1;
        core_hash = {8{$urandom}};
      end
    end
  end

  // Result monitor: compares against the scoreboard, holds, then acknowledges.
  initial begin
    exp_res_t e;
    result_ack = 1'b0; results_seen = 0;
    forever begin
      @(posedge clk); #1;
      if (result_valid) begin
        if (rq.size() == 0) begin
          check("unexpected_result", 256'(1), 256'(0));
          e = '{status: 2'(0), nonce: '0, hash: '0, chk_hash: 1'b0, chk_timing: 1'b0, ack_delay: 0};
        end else begin
          e = rq.pop_front();
          check("result_status", 256'(result_status), 256'(e.status));
          check("result_nonce", 256'(result_nonce), 256'(e.nonce));
          if (e.chk_hash) check("result_hash", result_hash, e.hash);
          if (e.chk_timing)
            check("timeout_latency", 256'(cyc - last_start_cyc), 256'(TB_TIMEOUT + 1));
        end
        for (int k = 0; k < e.ack_delay; k++) begin
          tick(1);
          check("hold_valid", 256'(result_valid), 256'(1));
          check("hold_nonce", 256'(result_nonce), 256'(e.nonce));
          check("hold_status", 256'(result_status), 256'(e.status));
        end
        result_ack = 1'b1; tick(1); result_ack = 1'b0;
        check("post_ack_valid", 256'(result_valid), 256'(0));
        check("post_ack_job_ready", 256'(job_ready), 256'(1));
        results_seen++;
      end
    end
  end

  // Stimulus.
  initial begin
    logic [255:0] ones, mid, tgt;
    logic [511:0] blk;
    logic [31:0] s, e;
    int k;
    errors = 0; checks = 0; last_start_cyc = 0; stray_req = 0;
    core_mode = MODE_NORMAL; core_lat = 4; abort_arm = 1'b0;
    rst = 1'b1; job_valid = 1'b0; job_midstate = '0; job_block2 = '0; job_target = '0;
    nonce_start = '0; nonce_end = '0;
    ones = '1;
    tick(3);
    check("rst_job_ready", 256'(job_ready), 256'(1));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_result_valid", 256'(result_valid), 256'(0));
    check("rst_core_start", 256'(core_start), 256'(0));
    check("rst_status", 256'(result_status), 256'(0));
    check("rst_nonce", 256'(result_nonce), 256'(0));
    check("rst_hash", result_hash, 256'(0));
    check("rst_core_mid", core_midstate, 256'(0));
    check("rst_core_blk", 256'(core_block2[511:256] | core_block2[255:0]), 256'(0));
    rst = 1'b0;
    tick(1);

    mid = {8{$urandom}}; blk = {16{$urandom}};
    run_job(mid, blk, ones, 32'd5, 32'd9, MODE_NORMAL, 64, 1);
    run_job(mid, blk, '0, 32'h10, 32'h13, MODE_NORMAL, 3, 0);
    run_job(mid, blk, '0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, MODE_NORMAL, 2, 2);
    run_job(mid, blk, ones, 32'h20, 32'h1F, MODE_NORMAL, 2, 0);
    run_job(mid, blk, ones, 32'h44, 32'h50, MODE_NODONE, 0, 1);
    run_job(mid, blk, ones, 32'h99, 32'hA0, MODE_ABORT, 4, 0);

    stray_req++;
    tick(3);
    check_idle("stray_done");

    // Reset in the middle of WAIT, with the core still due to answer later.
    core_lat = 64; core_mode = MODE_NORMAL;
    iq.push_back('{mid: mid, blk: with_nonce(blk, 32'h100), nonce: 32'h100});
    job_midstate = mid; job_block2 = blk; job_target = '0;
    nonce_start = 32'h100; nonce_end = 32'h1FF;
    job_valid = 1'b1; tick(1); job_valid = 1'b0;
    k = 0;
    while (!core_start && k < 50) begin tick(1); k++; end
    tick(5);
    rst = 1'b1; tick(1); rst = 1'b0;
    check_idle("after_rst");
    check("after_rst_hash", result_hash, 256'(0));
    check("after_rst_core_mid", core_midstate, 256'(0));
    tick(80);
    check_idle("late_done");
    run_job({8{$urandom}}, {16{$urandom}}, ones, 32'd7, 32'd12, MODE_NORMAL, 3, 10);

    for (int j = 0; j < 20; j++) begin
      mid = {8{$urandom}}; blk = {16{$urandom}};
      tgt = ($urandom_range(0, 3) == 0) ? '0 : {8{$urandom}};
      s = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
      e = s + 32'($urandom_range(0, 5));
      run_job(mid, blk, tgt, s, e, MODE_NORMAL, $urandom_range(1, 8), $urandom_range(0, 3));
    end

    tick(2);
    check("results_left", 256'(rq.size()), 256'(0));
    check("issues_left", 256'(iq.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nonce_sweep_scheduler.md
Name: nonce_sweep_scheduler

Overview:
- Sequences the SHA-256 mining datapath (midstate + second block → double hash) across a range of nonces.
- Accepts one job from the Raspberry Pi SPI FSM: midstate, block2 template, target, nonce range.
- For each nonce, inserts the nonce into block2, starts the hash core, waits for completion, and compares the hash against the target.
- Reports the first winning nonce, or exhaustion/timeout, back to the SPI FSM through a valid/ack handshake.

Parameters:
- NONCE_LSB, 127, bit index (0 = MSB, big-endian [0:511] numbering) of the last nonce bit in block2; nonce occupies [NONCE_LSB-31:NONCE_LSB].
- TIMEOUT_CYCLES, 255, maximum cycles to wait for core_done before declaring a core timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- job_valid  in  1  job presented by SPI FSM
- job_ready  out  1  scheduler idle and able to accept a job
- job_midstate  in  256  first-chunk midstate, [0:255] MSB-first
- job_block2  in  512  second-chunk template; nonce field ignored
- job_target  in  256  unsigned target, bit 0 = MSB
- nonce_start  in  32  first nonce tried
- nonce_end  in  32  last nonce tried (inclusive)
- abort  in  1  cancel current job
- core_start  out  1  one-cycle start pulse to hash core
- core_midstate  out  256  registered midstate to core
- core_block2  out  512  registered block2 with nonce inserted
- core_done  in  1  one-cycle pulse: core_hash valid
- core_hash  in  256  final double-SHA-256 result
- result_valid  out  1  result held until acked
- result_ack  in  1  SPI FSM consumed result
- result_status  out  2  0 = found, 1 = exhausted, 2 = timeout, 3 = aborted
- result_nonce  out  32  winning or last-tried nonce
- result_hash  out  256  hash of result_nonce (0 when aborted)
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE. All outputs 0 except job_ready=1. Internal counters and registers cleared. rst mid-job discards the job immediately; no result is produced, and a late core_done is ignored.
- IDLE: job_ready=1. On job_valid&&job_ready:
  - Register midstate, block2, target, nonce_start, nonce_end; cur_nonce=nonce_start; go to ISSUE.
  - If nonce_end<nonce_start (unsigned), go directly to REPORT with status=exhausted, nonce=nonce_start, hash=0.
- ISSUE (1 cycle):
  - core_block2 = template with [NONCE_LSB-31:NONCE_LSB] replaced by cur_nonce, written as-is (software pre-swaps endianness).
  - core_midstate = stored midstate; core_start=1 for exactly this cycle.
  - Clear timeout counter; go to WAIT.
  - core_* data holds stable from ISSUE until the next ISSUE.
- WAIT:
  - Timeout counter increments each cycle.
  - On core_done: capture core_hash and go to CHECK.
  - Else if counter==TIMEOUT_CYCLES: REPORT with status=timeout, nonce=cur_nonce.
- CHECK (1 cycle):
  - If captured hash < target (strict unsigned, bit 0 MSB): REPORT, status=found.
  - Else if cur_nonce==nonce_end: REPORT, status=exhausted, with last hash.
  - Else cur_nonce+1 and back to ISSUE.
  - Wrap-around: nonce_end=0xFFFFFFFF terminates on equality; cur_nonce never wraps to 0.
- Per-nonce cost: ISSUE + core latency + CHECK. The first core_start occurs the cycle after acceptance.
- REPORT:
  - result_valid=1; result_* stable until result_ack sampled high.
  - Then result_valid=0 and go to IDLE; job_ready=1 on the following cycle.
- abort:
  - In ISSUE/WAIT/CHECK: REPORT with status=aborted, nonce=cur_nonce, hash=0.
  - Ignored in IDLE and REPORT.
  - abort and core_done in the same cycle: abort wins.
  - abort in WAIT: the core's eventual core_done is ignored; the scheduler does not restart until back in ISSUE.
- Simultaneous job_valid with result_ack in REPORT: job not accepted (job_ready=0 that cycle).
- core_done outside WAIT is ignored.

Decomposition:
- Shared package mining_pkg:
  - sched_state_t enum {IDLE, ISSUE, WAIT, CHECK, REPORT}
  - result_status_t enum {FOUND=0, EXHAUSTED=1, TIMEOUT=2, ABORTED=3}
  - widths MIDSTATE_W=256, BLOCK_W=512, HASH_W=256, NONCE_W=32
- One natural sub-module, hash_target_compare: combinational 256-bit unsigned less-than, reusable by the SPI FSM for difficulty checks.

Test Plan:
- Job with target=all-ones, nonce_start=5, nonce_end=9, model core latency 64 → core_start once; status=found, nonce=5, hash=model hash, block2 bits [96:127]=0x00000005.
- target=0, nonce range 0x10..0x13 → exactly 4 core_start pulses, nonces 0x10–0x13 in order; status=exhausted, nonce=0x13.
- nonce_start=0xFFFFFFFE, nonce_end=0xFFFFFFFF, target=0 → 2 hashes; status=exhausted, no wrap to 0.
- Core model never asserts core_done → result_valid exactly TIMEOUT_CYCLES+1 cycles after core_start; status=timeout.
- abort asserted in WAIT in the same cycle as core_done → status=aborted, hash=0. A subsequent stray core_done in IDLE does not change outputs.
- rst pulsed mid-WAIT, then new job with target=all-ones, nonce_start=7 → outputs cleared the cycle after rst; new job yields found, nonce=7. result_valid holds 10 cycles until result_ack, then job_ready=1.
